ff_register_file_1r_1w_bist: RTL
================================

# ff_register_file_1r_1w_bist

Parametrised flip-flop register file (1 read, 1 write, byte enables) with an integrated March C- self-test engine replacing externally driven BIST pins. It sits wherever a standard-cell-memory register file is instanced and needs production self-test without a tester-side memory BIST controller. Functional ports are used in normal mode. While a self-test runs, the internal engine owns the array and reports pass/fail plus the first failing address.

## Interface
- ADDR_WIDTH, 5, address bits; depth N = 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width; must be a multiple of 8
- NUM_BYTE, DATA_WIDTH/8, byte-enable count
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ReadEnable  in  1  functional read request
- ReadAddr  in  ADDR_WIDTH  functional read address
- ReadData  out  DATA_WIDTH  registered read data; reset 0
- WriteEnable  in  1  functional write request
- WriteAddr  in  ADDR_WIDTH  functional write address
- WriteData  in  NUM_BYTE x 8  functional write data
- WriteBE  in  NUM_BYTE  byte enables, 1 = write byte
- BistStart  in  1  start self-test; sampled in IDLE only
- BistBusy  out  1  self-test running; reset 0
- BistDone  out  1  level, test finished; reset 0
- BistFail  out  1  sticky mismatch flag; reset 0
- BistFailAddr  out  ADDR_WIDTH  address of first mismatch; reset 0

## Operation
- Array: N x DATA_WIDTH flops, all cleared to 0 by rst_n.
- Write: WriteEnable high → bytes with WriteBE=1 at WriteAddr update on the edge.
- Read: ReadEnable high → ReadData <= array[ReadAddr] on the edge; otherwise ReadData holds.
- Same-address read+write in one cycle: ReadData gets the old word.
- While BistBusy=1, all functional inputs are ignored. ReadData shows engine reads.
- Engine FSM states: IDLE, W0, RW_R, RW_W, FINAL_R, CHECK, DONE.
- IDLE + BistStart=1 → W0. This transition clears BistFail, BistFailAddr and BistDone, and sets BistBusy.
- March C- elements (BE all ones, background 0 = all-zero, 1 = all-one):
  - E0 ⇑ w0
  - E1 ⇑ (r0, w1)
  - E2 ⇑ (r1, w0)
  - E3 ⇓ (r0, w1)
  - E4 ⇓ (r1, w0)
  - E5 ⇓ r0
- W0 and FINAL_R issue one operation per cycle.
- Read-write elements alternate RW_R (read addr a) and RW_W (write addr a). The compare of the RW_R data happens during RW_W.
- Address counter wraps 0→N-1 (⇑) or N-1→0 (⇓). Element index advances at the wrap.
- A mismatch sets BistFail. BistFailAddr latches only on the first mismatch. The test always runs to completion.
- CHECK compares the final read. DONE deasserts BistBusy and asserts BistDone; both hold until the next BistStart.
- BistStart while busy: ignored.
- rst_n low at any point: FSM → IDLE, all flags 0, array cleared.

## Timing
- Functional read latency is 1 cycle. Write data is visible to a read issued on the following cycle.
- Self-test length: 10N array cycles + 1 CHECK cycle.
- BistDone rises 10N+2 edges after the edge that samples BistStart (N=32 → 322).
- BistBusy is high from the edge after BistStart through CHECK.
- After the test the array holds all zeros.

## Configuration
- Macro: SCM_BIST_EN.
- Defined: engine compiled in as described above.
- Undefined: engine and mux are removed. BistStart is ignored. BistBusy, BistDone and BistFail are tied 0, and BistFailAddr is tied 0. Functional path timing is unchanged.

## Structure
- Package scm_bist_pkg holds:
  - bist_state_e enum (7 states)
  - march element typedef: direction, read value, write value, has-read, has-write
  - localparam table of the 6 March C- elements
- Sub-module scm_march_engine: FSM, address/element counters and comparator. It emits req/we/addr/wdata and consumes rdata. Instanced only under SCM_BIST_EN.
- Top level holds the array, the functional/BIST mux and the ReadData register.

## Test plan
- Functional: write 0xDEADBEEF to addr 3 with BE=4'b1111, then write 0x000000AA with BE=4'b0001, then read addr 3 → ReadData=0xDEADBEAA one cycle after ReadEnable.
- Same-cycle read+write of addr 7 (old 0x11111111, new 0x22222222) → ReadData=0x11111111. A read on the next cycle → 0x22222222.
- Clean self-test with default parameters: pulse BistStart → BistBusy high for 321 cycles, BistDone at edge 322, BistFail=0. Afterwards all words read 0.
- Fault: force array[5] bit 3 stuck-at-1, run self-test → BistFail=1, BistFailAddr=5, BistDone asserted.
- Assert rst_n low mid-test (cycle 100) → BistBusy, BistDone and BistFail read 0 immediately. BistStart after reset runs the full 322 cycles.
- ADDR_WIDTH=2, DATA_WIDTH=16: clean self-test → BistDone at edge 42. Functional writes during BistBusy leave the array unchanged.

Source files
------------

// File: rtl/scm_bist_pkg.sv
// Shared types for the flop register file self-test: engine states and the
// March C- element table walked by scm_march_engine.
package scm_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_RW_R,
    ST_RW_W,
    ST_FINAL_R,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  typedef struct packed {
    logic down;    // 1 = descending address order
    logic rval;    // expected background on read
    logic wval;    // background written
    logic has_rd;
    logic has_wr;
  } march_elem_t;

  localparam int NUM_ELEM = 6;

  localparam march_elem_t MARCH_C_MINUS [NUM_ELEM] = '{
    '{down: 1'b0, rval: 1'b0, wval: 1'b0, has_rd: 1'b0, has_wr: 1'b1},  // up   w0
    '{down: 1'b0, rval: 1'b0, wval: 1'b1, has_rd: 1'b1, has_wr: 1'b1},  // up   r0,w1
    '{down: 1'b0, rval: 1'b1, wval: 1'b0, has_rd: 1'b1, has_wr: 1'b1},  // up   r1,w0
    '{down: 1'b1, rval: 1'b0, wval: 1'b1, has_rd: 1'b1, has_wr: 1'b1},  // down r0,w1
    '{down: 1'b1, rval: 1'b1, wval: 1'b0, has_rd: 1'b1, has_wr: 1'b1},  // down r1,w0
    '{down: 1'b1, rval: 1'b0, wval: 1'b0, has_rd: 1'b1, has_wr: 1'b0}   // down r0
  };

  // State in which an element's first operation is issued.
  function automatic bist_state_e elem_entry_state(input march_elem_t e);
    if (e.has_rd && e.has_wr) return ST_RW_R;
    if (e.has_wr)             return ST_W0;
    return ST_FINAL_R;
  endfunction

endpackage

// File: rtl/scm_march_engine.sv
// March C- self-test engine: FSM, address/element counters and read comparator.
// Only instanced when SCM_BIST_EN is defined.
module scm_march_engine
  import scm_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  own_o,
  output logic                  re_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o
);

  bist_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            elem_q, elem_d;
  logic [2:0]            elem_nxt;
  logic                  last_addr;
  logic                  start_take;

  logic                  rd_pend_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_exp_q;
  logic                  busy_q, done_q, fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;

  assign start_take = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign elem_nxt   = (elem_q == 3'(NUM_ELEM - 1)) ? elem_q : elem_q + 3'd1;
  assign last_addr  = MARCH_C_MINUS[elem_q].down ? (addr_q == '0) : (addr_q == '1);
  assign own_o      = state_q inside {ST_W0, ST_RW_R, ST_RW_W, ST_FINAL_R, ST_CHECK};
  assign addr_o     = addr_q;
  assign wdata_o    = {DATA_WIDTH{MARCH_C_MINUS[elem_q].wval}};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    elem_d  = elem_q;
    re_o    = 1'b0;
    we_o    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_W0;
          addr_d  = '0;
          elem_d  = '0;
        end
      end
      ST_W0, ST_RW_W: begin
        we_o = 1'b1;
        if (last_addr) begin
          // Element complete: move to the next one at its starting corner.
          elem_d  = elem_nxt;
          addr_d  = MARCH_C_MINUS[elem_nxt].down ? '1 : '0;
          state_d = elem_entry_state(MARCH_C_MINUS[elem_nxt]);
        end else begin
          addr_d  = MARCH_C_MINUS[elem_q].down ? addr_q - 1'b1 : addr_q + 1'b1;
          state_d = (state_q == ST_RW_W) ? ST_RW_R : ST_W0;
        end
      end
      ST_RW_R: begin
        re_o    = 1'b1;
        state_d = ST_RW_W;
      end
      ST_FINAL_R: begin
        re_o = 1'b1;
        if (last_addr) state_d = ST_CHECK;
        else addr_d = MARCH_C_MINUS[elem_q].down ? addr_q - 1'b1 : addr_q + 1'b1;
      end
      ST_CHECK: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A read issued in one cycle is compared the next, when its data sits in ReadData.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      elem_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_exp_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      addr_q    <= addr_d;
      elem_q    <= elem_d;
      busy_q    <= own_o;
      done_q    <= (state_q == ST_DONE) && !start_take;
      rd_addr_q <= addr_q;
      rd_exp_q  <= MARCH_C_MINUS[elem_q].rval;
      if (start_take) begin
        rd_pend_q   <= 1'b0;
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
      end else begin
        rd_pend_q <= re_o;
        if (rd_pend_q && (rdata_i != {DATA_WIDTH{rd_exp_q}})) begin
          fail_q <= 1'b1;
          if (!fail_q) fail_addr_q <= rd_addr_q;
        end
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;

endmodule

// File: rtl/ff_register_file_1r_1w_bist.sv
// Flip-flop register file, 1 read / 1 write with byte enables, registered read.
// Define SCM_BIST_EN to compile in the March C- self-test engine and its array mux.
module ff_register_file_1r_1w_bist
  import scm_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ReadEnable,
  input  logic [ADDR_WIDTH-1:0] ReadAddr,
  output logic [DATA_WIDTH-1:0] ReadData,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [NUM_BYTE*8-1:0] WriteData,
  input  logic [NUM_BYTE-1:0]   WriteBE,
  input  logic                  BistStart,
  output logic                  BistBusy,
  output logic                  BistDone,
  output logic                  BistFail,
  output logic [ADDR_WIDTH-1:0] BistFailAddr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0]            rdata_q;

  logic                  arr_re, arr_we;
  logic [ADDR_WIDTH-1:0] arr_raddr, arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [NUM_BYTE-1:0]   arr_be;

`ifdef SCM_BIST_EN
  logic                  eng_own, eng_re, eng_we;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [DATA_WIDTH-1:0] eng_wdata;

  scm_march_engine #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_engine (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (BistStart),
    .own_o       (eng_own),
    .re_o        (eng_re),
    .we_o        (eng_we),
    .addr_o      (eng_addr),
    .wdata_o     (eng_wdata),
    .rdata_i     (rdata_q),
    .busy_o      (BistBusy),
    .done_o      (BistDone),
    .fail_o      (BistFail),
    .fail_addr_o (BistFailAddr)
  );

  // While the engine owns the array the functional ports are ignored entirely.
  always_comb begin
    arr_re    = ReadEnable;
    arr_raddr = ReadAddr;
    arr_we    = WriteEnable;
    arr_waddr = WriteAddr;
    arr_wdata = WriteData;
    arr_be    = WriteBE;
    if (eng_own) begin
      arr_re    = eng_re;
      arr_raddr = eng_addr;
      arr_we    = eng_we;
      arr_waddr = eng_addr;
      arr_wdata = eng_wdata;
      arr_be    = '1;
    end
  end
`else
  logic bist_start_unused;

  assign bist_start_unused = BistStart;
  assign arr_re            = ReadEnable;
  assign arr_raddr         = ReadAddr;
  assign arr_we            = WriteEnable;
  assign arr_waddr         = WriteAddr;
  assign arr_wdata         = WriteData;
  assign arr_be            = WriteBE;
  assign BistBusy          = 1'b0;
  assign BistDone          = 1'b0;
  assign BistFail          = 1'b0;
  assign BistFailAddr      = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is real flops, so clearing it on reset is intended and cheap to verify.
      mem_q <= '0;
    end else if (arr_we) begin
      for (int b = 0; b < NUM_BYTE; b++) begin
        if (arr_be[b]) mem_q[arr_waddr][b*8 +: 8] <= arr_wdata[b*8 +: 8];
      end
    end
  end

  // Read samples the pre-edge array, so a same-address write returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rdata_q <= '0;
    else if (arr_re) rdata_q <= mem_q[arr_raddr];
  end

  assign ReadData = rdata_q;

endmodule
